// File: rtl/shift_add_multiplier_module_pkg.sv
// shift_add_multiplier_module_pkg: W4 common state encodings and default width.
package shift_add_multiplier_module_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/shift_add_multiplier_module_ripple_adder_4bit.sv
// ripple_adder_4bit: chained full adders, carry ripples from cin to cout.
module ripple_adder_4bit
   import shift_add_multiplier_module_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier_module.sv
// shift_add_multiplier_module: sequential unsigned shift-and-add multiplier,
// one conditional add plus right shift per cycle through a ripple adder.
module shift_add_multiplier_module
   import shift_add_multiplier_module_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);
   state_t           state, state_next;
   logic [WIDTH-1:0] m, p_hi, q, add_a, sum;
   logic [CW-1:0]    count;
   logic             cout, accept, last;
   ripple_adder_4bit #(.WIDTH(WIDTH)) u_adder (
      .a   (add_a),
      .b   (p_hi),
      .cin (1'b0),
      .sum (sum),
      .cout(cout)
   );
   assign add_a = q[0] ? m : '0;
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end
   always_comb begin
      accept     = start && (state != S_BUSY);
      last       = (state == S_BUSY) && (count == CW'(WIDTH-1));
      state_next = accept ? S_BUSY : (state == S_BUSY) ? (last ? S_DONE : S_BUSY) : S_IDLE;
      busy       = (state == S_BUSY);
      done       = (state == S_DONE);
   end
   // {cout,sum,q} >> 1: cout lands in p_hi MSB, sum LSB enters q MSB
   always_ff @(posedge clk) begin
      if (reset) begin
         m       <= '0;
         p_hi    <= '0;
         q       <= '0;
         count   <= '0;
         product <= '0;
      end else if (accept) begin
         m     <= a;
         q     <= b;
         p_hi  <= '0;
         count <= '0;
      end else if (state == S_BUSY) begin
         p_hi  <= {cout, sum[WIDTH-1:1]};
         q     <= {sum[0], q[WIDTH-1:1]};
         count <= count + 1'b1;
         if (last) product <= {cout, sum, q[WIDTH-1:1]};
      end
   end
endmodule

// File: tb/tb_shift_add_multiplier_module.sv
// tb_shift_add_multiplier_module: vector table, hand sequences and random
// operands checked against plain a*b.
module tb_shift_add_multiplier_module;
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;
   logic       clk = 0, reset = 1, start = 0;
   logic [3:0] a = 0, b = 0;
   logic       busy, done;
   logic [7:0] product;
   int         n_checks = 0, n_fail = 0;
   vec_t       vecs [8];
   shift_add_multiplier_module dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // accept, 4 busy cycles with operand noise and a stray start, then done pulse
   task automatic run_mult(input string name, input logic [3:0] ma, input logic [3:0] mb);
      logic [7:0] exp;
      exp = 8'(ma * mb);
      a = ma; b = mb; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 4; c++) begin
         check({name, " busy"}, {8'h0, busy, done}, 10'b10);
         a = 4'($urandom); b = 4'($urandom);
         start = (c == 1);
         step();
         start = 0;
      end
      check({name, " done"}, {busy, done, product}, {2'b01, exp});
      step();
      check({name, " hold"}, {busy, done, product}, {2'b00, exp});
   endtask
   initial begin
      vecs[0] = '{4'd6,  4'd5,  8'd30};
      vecs[1] = '{4'hF,  4'hF,  8'hE1};
      vecs[2] = '{4'd0,  4'd9,  8'h00};
      vecs[3] = '{4'd9,  4'd0,  8'h00};
      vecs[4] = '{4'd1,  4'd1,  8'd1};
      vecs[5] = '{4'd8,  4'd8,  8'h40};
      vecs[6] = '{4'hF,  4'd1,  8'd15};
      vecs[7] = '{4'd10, 4'd13, 8'd130};
      step(); step();
      check("reset", {busy, done, product}, 10'h0);
      reset = 0;
      step();
      check("idle", {busy, done, product}, 10'h0);
      for (int i = 0; i < 8; i++) begin
         a = vecs[i].a; b = vecs[i].b; start = 1;
         step();
         start = 0;
         repeat (3) step();
         check($sformatf("vec%0d pre", i), {8'h0, busy, done}, 10'b10);
         step();
         check($sformatf("vec%0d", i), {busy, done, product}, {2'b01, vecs[i].p});
         step();
      end
      run_mult("6x5", 4'd6, 4'd5);
      // back-to-back with start held: second accept on the done edge
      a = 4'd3; b = 4'd7; start = 1;
      step();
      a = 4'd12; b = 4'd11;
      repeat (4) step();
      check("b2b first", {busy, done, product}, {2'b01, 8'd21});
      step();
      a = 4'd5; b = 4'd5;
      check("b2b accept", {busy, done, product}, {2'b10, 8'd21});
      start = 0;
      repeat (3) step();
      check("b2b mid", {busy, done, product}, {2'b10, 8'd21});
      step();
      check("b2b second", {busy, done, product}, {2'b01, 8'd132});
      step();
      check("b2b idle", {busy, done, product}, {2'b00, 8'd132});
      // reset mid-operation abandons the multiply
      a = 4'd13; b = 4'd13; start = 1;
      step();
      start = 0;
      step();
      reset = 1;
      step();
      check("abort", {busy, done, product}, 10'h0);
      reset = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("abort quiet", {8'h0, busy, done}, 10'b00);
      end
      run_mult("2x3", 4'd2, 4'd3);
      for (int i = 0; i < 20; i++)
         run_mult($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
